lane_tick_scheduler: RTL and testbench

Generates the per-lane vehicle shift strobes that sequence the vehicle-lane datapath (NIVEL_VEHICULOS). Each of the 6 lanes advances at a level-dependent period. The datapath accepts at most one lane shift per clock, so the block holds pending shift requests and grants them one-hot by round-robin. It is gated by the main-menu state and freezes briefly after a win or loss.

---
 rtl/lane_pkg.sv | 18 +
 rtl/rr_arbiter6.sv | 27 ++
 rtl/lane_tick_scheduler.sv | 176 +++++++++++++++++
 tb/tb_lane_tick_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lane_pkg.sv
// Shared constants and types for the vehicle-lane tick scheduler and its arbiter.
package lane_pkg;

   localparam int NUM_LANES  = 6;
   localparam int LANE_IDX_W = 3;

   localparam logic [4*NUM_LANES-1:0] LANE_BASE_DEFAULT = 24'h742635;

   localparam logic [2:0] ESTADO_MENU    = 3'd0;
   localparam logic [2:0] ESTADO_JUGANDO = 3'd1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FREEZE = 2'd2
   } lts_state_t;

endpackage

// File: rtl/rr_arbiter6.sv
// Combinational six-way round-robin picker: first request after i_ptr, wrapping modulo 6.
module rr_arbiter6
   import lane_pkg::*;
(
   input  logic [NUM_LANES-1:0]  i_req,
   input  logic [LANE_IDX_W-1:0] i_ptr,
   output logic [NUM_LANES-1:0]  o_gnt,
   output logic [LANE_IDX_W-1:0] o_idx
);

   logic [LANE_IDX_W-1:0] w_cand;

   // Scan farthest-first so the nearest candidate after the pointer overwrites the rest.
   always_comb begin
      o_gnt  = '0;
      o_idx  = '0;
      w_cand = '0;
      for (int k = NUM_LANES; k >= 1; k--) begin
         w_cand = LANE_IDX_W'((int'(i_ptr) + k) % NUM_LANES);
         if (i_req[w_cand]) begin
            o_idx = w_cand;
            o_gnt = NUM_LANES'(1) << w_cand;
         end
      end
   end

endmodule

// File: rtl/lane_tick_scheduler.sv
// Per-lane shift strobe scheduler: level-scaled lane periods, one grant per clock, freeze on win/loss.
// Define LANE_TICK_STEP_EN to replace the prescaler with a registered rising edge of LTS_STEP_IN.
module lane_tick_scheduler
   import lane_pkg::*;
#(
   parameter int                          DATAWIDTH_ESTADO = 3,
   parameter int                          DATAWIDTH_NV     = 2,
   parameter int                          NUM_LANES        = lane_pkg::NUM_LANES,
   parameter int                          PRESCALE_W       = 24,
   parameter int                          BASE_PERIOD      = 12500000,
   parameter logic [4*NUM_LANES-1:0]      LANE_BASE        = lane_pkg::LANE_BASE_DEFAULT,
   parameter logic [DATAWIDTH_ESTADO-1:0] ESTADO_JUEGO     = DATAWIDTH_ESTADO'(lane_pkg::ESTADO_JUGANDO),
   parameter int                          FREEZE_TICKS     = 4
) (
   input  logic                        LTS_CLOCK,
   input  logic                        LTS_RESET,
   input  logic [DATAWIDTH_ESTADO-1:0] LTS_ESTADO_IN,
   input  logic [DATAWIDTH_NV-1:0]     LTS_NV_IN,
   input  logic                        LTS_PERDIO_IN,
   input  logic                        LTS_GANO_IN,
`ifdef LANE_TICK_STEP_EN
   input  logic                        LTS_STEP_IN,
`endif
   output logic [NUM_LANES-1:0]        LTS_SHIFT_OUT,
   output logic [LANE_IDX_W-1:0]       LTS_LANE_OUT,
   output logic                        LTS_VALID_OUT,
   output logic                        LTS_RUN_OUT,
   output logic                        LTS_OVERRUN_OUT
);

   localparam int                    FCNT_W   = $clog2(FREEZE_TICKS + 1);
   localparam logic [FCNT_W-1:0]     FCNT_END = FCNT_W'(FREEZE_TICKS - 1);
   localparam logic [LANE_IDX_W-1:0] PTR_RST  = LANE_IDX_W'(NUM_LANES - 1);

   lts_state_t                  r_state, w_next;
   logic [FCNT_W-1:0]           r_fcnt;
   logic [3:0]                  r_cnt [NUM_LANES];
   logic [NUM_LANES-1:0]        r_pend;
   logic [LANE_IDX_W-1:0]       r_ptr;
   logic [NUM_LANES-1:0]        r_shift;
   logic [LANE_IDX_W-1:0]       r_lane;
   logic                        r_valid;
   logic                        r_overrun;

   logic                        w_playing, w_hit, w_tick_src, w_tick;
   logic                        w_clear, w_run_act, w_freeze_exit, w_any;
   logic [4:0]                  w_per [NUM_LANES];
   logic [NUM_LANES-1:0]        w_expire;
   logic [NUM_LANES-1:0]        w_gnt;
   logic [LANE_IDX_W-1:0]       w_gnt_idx;

   // Base levels of 2*NV shorten the period; anything that would drop below one tick pins at 1.
   function automatic logic [4:0] lane_period(input logic [3:0] base, input logic [DATAWIDTH_NV-1:0] nv);
      logic [4:0] dec;
      dec = 5'(nv) << 1;
      if ({1'b0, base} <= dec) return 5'd1;
      return {1'b0, base} - dec;
   endfunction

   assign w_playing = (LTS_ESTADO_IN == ESTADO_JUEGO);
   assign w_hit     = LTS_PERDIO_IN | LTS_GANO_IN;

`ifdef LANE_TICK_STEP_EN
   logic r_step_d, r_step_tick;

   always_ff @(posedge LTS_CLOCK or posedge LTS_RESET) begin
      if (LTS_RESET) begin
         r_step_d    <= 1'b0;
         r_step_tick <= 1'b0;
      end else begin
         r_step_d    <= LTS_STEP_IN;
         r_step_tick <= LTS_STEP_IN & ~r_step_d;
      end
   end

   assign w_tick_src = r_step_tick;
`else
   logic [PRESCALE_W-1:0] r_presc;

   always_ff @(posedge LTS_CLOCK or posedge LTS_RESET) begin
      if (LTS_RESET)                                 r_presc <= '0;
      else if (w_clear)                              r_presc <= '0;
      else if (r_presc == PRESCALE_W'(BASE_PERIOD - 1)) r_presc <= '0;
      else                                           r_presc <= r_presc + 1'b1;
   end

   assign w_tick_src = (r_presc == PRESCALE_W'(BASE_PERIOD - 1));
`endif

   assign w_tick = w_tick_src && (r_state != ST_IDLE);

   always_ff @(posedge LTS_CLOCK or posedge LTS_RESET) begin
      if (LTS_RESET) r_state <= ST_IDLE;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (!w_playing) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:   w_next = ST_RUN;
            ST_RUN:    if (w_hit) w_next = ST_FREEZE;
            ST_FREEZE: if (w_tick && (r_fcnt == FCNT_END)) w_next = ST_RUN;
            default:   w_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_clear       = !w_playing || (r_state == ST_IDLE);
      w_run_act     = w_playing && (r_state == ST_RUN) && !w_hit;
      w_freeze_exit = w_playing && (r_state == ST_FREEZE) && w_tick && (r_fcnt == FCNT_END);
   end

   always_comb begin
      w_expire = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         w_per[i]    = lane_period(LANE_BASE[4*i +: 4], LTS_NV_IN);
         w_expire[i] = w_run_act && w_tick && ({1'b0, r_cnt[i]} >= (w_per[i] - 5'd1));
      end
   end

   rr_arbiter6 u_arb (
      .i_req (r_pend),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_gnt_idx)
   );

   assign w_any = |r_pend;

   always_ff @(posedge LTS_CLOCK or posedge LTS_RESET) begin
      if (LTS_RESET)                 r_fcnt <= '0;
      else if (w_next != ST_FREEZE)  r_fcnt <= '0;
      else if ((r_state == ST_FREEZE) && w_tick) r_fcnt <= r_fcnt + 1'b1;
   end

   always_ff @(posedge LTS_CLOCK or posedge LTS_RESET) begin
      if (LTS_RESET) begin
         for (int i = 0; i < NUM_LANES; i++) r_cnt[i] <= '0;
      end else if (w_clear || w_freeze_exit) begin
         for (int i = 0; i < NUM_LANES; i++) r_cnt[i] <= '0;
      end else if (w_run_act && w_tick) begin
         for (int i = 0; i < NUM_LANES; i++) r_cnt[i] <= w_expire[i] ? 4'd0 : r_cnt[i] + 4'd1;
      end
   end

   // A lane set and granted on the same edge stays pending: the new expiry is not lost.
   always_ff @(posedge LTS_CLOCK or posedge LTS_RESET) begin
      if (LTS_RESET) begin
         r_pend    <= '0;
         r_ptr     <= PTR_RST;
         r_shift   <= '0;
         r_lane    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_pend  <= w_run_act ? ((r_pend & ~w_gnt) | w_expire) : '0;
         r_shift <= w_run_act ? w_gnt : '0;
         r_lane  <= (w_run_act && w_any) ? w_gnt_idx : '0;
         r_valid <= w_run_act && w_any;
         if (w_run_act && w_any) r_ptr <= w_gnt_idx;
         if (w_clear)                                      r_overrun <= 1'b0;
         else if (|(w_expire & r_pend & ~w_gnt))           r_overrun <= 1'b1;
      end
   end

   assign LTS_SHIFT_OUT   = r_shift;
   assign LTS_LANE_OUT    = r_lane;
   assign LTS_VALID_OUT   = r_valid;
   assign LTS_RUN_OUT     = (r_state == ST_RUN);
   assign LTS_OVERRUN_OUT = r_overrun;

endmodule

// File: tb/tb_lane_tick_scheduler.sv
// Directed scoreboard bench for lane_tick_scheduler: grant order, level change, freeze, idle, reset, overrun.
module tb_lane_tick_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] estado = 3'd0, estado_o = 3'd0;
   logic [1:0] nv = 2'd3, nv_o = 2'd0;
   logic       perdio = 1'b0, gano = 1'b0, zero = 1'b0;

   logic [5:0] shift, shift_o;
   logic [2:0] lane, lane_o;
   logic       valid, run, ovr, valid_o, run_o, ovr_o;

   int cyc = 0;
   int n_chk = 0, n_pass = 0, n_fail = 0;
   bit mon_en = 1'b0;

   typedef struct { int cyc; int lane; } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lane_tick_scheduler #(.BASE_PERIOD(8)) u_dut (
      .LTS_CLOCK(clk), .LTS_RESET(rst), .LTS_ESTADO_IN(estado), .LTS_NV_IN(nv),
      .LTS_PERDIO_IN(perdio), .LTS_GANO_IN(gano),
`ifdef LANE_TICK_STEP_EN
      .LTS_STEP_IN(zero),
`endif
      .LTS_SHIFT_OUT(shift), .LTS_LANE_OUT(lane), .LTS_VALID_OUT(valid),
      .LTS_RUN_OUT(run), .LTS_OVERRUN_OUT(ovr)
   );

   lane_tick_scheduler #(.BASE_PERIOD(1), .LANE_BASE(24'h111111)) u_ovr (
      .LTS_CLOCK(clk), .LTS_RESET(rst), .LTS_ESTADO_IN(estado_o), .LTS_NV_IN(nv_o),
      .LTS_PERDIO_IN(zero), .LTS_GANO_IN(zero),
`ifdef LANE_TICK_STEP_EN
      .LTS_STEP_IN(zero),
`endif
      .LTS_SHIFT_OUT(shift_o), .LTS_LANE_OUT(lane_o), .LTS_VALID_OUT(valid_o),
      .LTS_RUN_OUT(run_o), .LTS_OVERRUN_OUT(ovr_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int c, input int l);
      exp_t e;
      e.cyc  = c;
      e.lane = l;
      sb.push_back(e);
   endtask

   // Strobe monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         chk("dut_onehot", 32'($onehot0(shift)), 32'd1);
         chk("dut_valid_or", 32'(valid), 32'(|shift));
         if (valid) begin
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("strobe_cyc", 32'(cyc), 32'(e.cyc));
               chk("strobe_lane", 32'(lane), 32'(e.lane));
               chk("strobe_shift", 32'(shift), 32'(1) << e.lane);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, c2;
      wait_cyc(2);
      @(negedge clk);
      chk("rst_shift", 32'(shift), 0);   chk("rst_lane", 32'(lane), 0);
      chk("rst_valid", 32'(valid), 0);   chk("rst_run", 32'(run), 0);
      chk("rst_ovr", 32'(ovr), 0);       chk("rst_shift_o", 32'(shift_o), 0);
      chk("rst_valid_o", 32'(valid_o), 0); chk("rst_ovr_o", 32'(ovr_o), 0);
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(5);
      @(negedge clk);
      chk("idle_run", 32'(run), 0);

      // All six lanes at period 1 (NV=3): two full bursts in lane order.
      c0 = 6;
      wait_cyc(c0);
      mon_en = 1'b1;
      estado = 3'd1;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 6; i++) push(c0 + 10 + 8*b + i, i);
      wait_cyc(c0 + 1);
      @(negedge clk);
      chk("run_entered", 32'(run), 1);

      // Level 0: lane 3 (period 2) then lane 1 (period 3); then level 2 mid-count.
      wait_cyc(c0 + 18);
      nv = 2'd0;
      push(c0 + 34, 3);
      push(c0 + 42, 1);
      wait_cyc(c0 + 42);
      nv = 2'd2;
      push(c0 + 50, 2); push(c0 + 51, 3); push(c0 + 52, 4);
      push(c0 + 53, 5); push(c0 + 54, 0); push(c0 + 55, 1);
      push(c0 + 58, 3); push(c0 + 59, 4); push(c0 + 60, 0); push(c0 + 61, 1);
      wait_cyc(c0 + 62);
      chk("sb_drained_lvl", 32'(sb.size()), 0);
      chk("no_ovr_lvl", 32'(ovr), 0);

      // Loss pulse coinciding with an expiry edge.
      wait_cyc(c0 + 64);
      perdio = 1'b1;
      wait_cyc(c0 + 65);
      perdio = 1'b0;
      @(negedge clk);
      chk("freeze_run_lo", 32'(run), 0);
      push(c0 + 106, 3); push(c0 + 107, 4); push(c0 + 108, 0); push(c0 + 109, 1);
      wait_cyc(c0 + 96);
      @(negedge clk);
      chk("freeze_run_end", 32'(run), 0);
      wait_cyc(c0 + 97);
      @(negedge clk);
      chk("freeze_exit_run", 32'(run), 1);

      // Leave the playing state while lanes are still pending.
      push(c0 + 114, 2); push(c0 + 115, 3);
      wait_cyc(c0 + 115);
      estado = 3'd0;
      wait_cyc(c0 + 116);
      @(negedge clk);
      chk("idle_shift", 32'(shift), 0);
      chk("idle_valid", 32'(valid), 0);
      chk("idle_run2", 32'(run), 0);
      chk("idle_ovr", 32'(ovr), 0);
      wait_cyc(c0 + 119);
      chk("sb_drained_idle", 32'(sb.size()), 0);

      // Re-entry starts from cleared counters/pending; pointer is kept (last grant lane 3).
      c1 = c0 + 120;
      wait_cyc(c1);
      estado = 3'd1;
      push(c1 + 10, 4); push(c1 + 11, 0); push(c1 + 12, 1); push(c1 + 13, 3);
      wait_cyc(c1 + 11);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("async_shift", 32'(shift), 0);
      chk("async_lane", 32'(lane), 0);
      chk("async_valid", 32'(valid), 0);
      chk("async_run", 32'(run), 0);
      chk("async_ovr", 32'(ovr), 0);
      sb.delete();
      wait_cyc(c1 + 13);
      rst = 1'b0;
      push(c1 + 23, 0); push(c1 + 24, 1); push(c1 + 25, 3); push(c1 + 26, 4);
      wait_cyc(c1 + 30);
      chk("sb_drained_rst", 32'(sb.size()), 0);
      estado = 3'd0;

      // Overrun instance: tick every clock, all lanes period 1.
      c2 = c1 + 32;
      wait_cyc(c2);
      estado_o = 3'd1;
      wait_cyc(c2 + 2);
      @(negedge clk);
      chk("ovr_pre", 32'(ovr_o), 0);
      chk("ovr_pre_valid", 32'(valid_o), 0);
      wait_cyc(c2 + 3);
      @(negedge clk);
      chk("ovr_set", 32'(ovr_o), 1);
      chk("ovr_first_lane", 32'(lane_o), 0);
      chk("ovr_first_shift", 32'(shift_o), 32'h01);
      wait_cyc(c2 + 4);
      @(negedge clk);
      chk("ovr_second_lane", 32'(lane_o), 1);
      wait_cyc(c2 + 10);
      @(negedge clk);
      chk("ovr_sticky", 32'(ovr_o), 1);
      chk("ovr_onehot", 32'($onehot(shift_o)), 1);
      chk("ovr_run", 32'(run_o), 1);
      estado_o = 3'd0;
      wait_cyc(c2 + 11);
      @(negedge clk);
      chk("ovr_cleared", 32'(ovr_o), 0);
      chk("ovr_idle_valid", 32'(valid_o), 0);
      chk("ovr_idle_run", 32'(run_o), 0);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
